// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA frame monitor.
//   rgb_t           : packed 8-bit R/G/B pixel
//   monitor_state_t : statistics FSM states
//   luma()          : (R + 2G + B) >> 2, computed at 10 bits, returned as 8 bits
package vga_pkg;

  // Width of the x/y position counters and of the reported line count.
  localparam int POS_W = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    SEEK  = 1'b0,
    FRAME = 1'b1
  } monitor_state_t;

  function automatic logic [7:0] luma(input rgb_t px);
    logic [9:0] acc;
    acc = {2'b00, px.r} + {1'b0, px.g, 1'b0} + {2'b00, px.b};
    return acc[9:2];
  endfunction

endpackage

// File: rtl/vga_position_counter.sv
// Pixel position tracker for a BLANK_N/VS framed video stream.
//   i_clk, i_srst   : clock, synchronous active-high reset
//   i_blank_n, i_vs : stream framing inputs
//   o_x, o_y        : position of the current input pixel (forced to 0,0 on vs_fall)
//   o_lines         : completed lines in the current frame (value before this cycle)
//   o_vs_fall       : previous VS high, current VS low
//   o_len_err       : a line closed this cycle with length != WIDTH
module vga_position_counter
  import vga_pkg::*;
#(
  parameter int WIDTH = 800
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_blank_n,
  input  logic             i_vs,
  output logic [POS_W-1:0] o_x,
  output logic [POS_W-1:0] o_y,
  output logic [POS_W-1:0] o_lines,
  output logic             o_vs_fall,
  output logic             o_len_err
);

  localparam logic [POS_W-1:0] WIDTH_P = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic             r_vs_prev;
  logic [POS_W-1:0] r_x;
  logic [POS_W-1:0] r_y;
  logic             w_vs_fall;
  logic             w_line_open;
  logic             w_line_close;

  assign w_vs_fall   = r_vs_prev & ~i_vs;
  // x is non-zero exactly while an active run is in progress.
  assign w_line_open = (r_x != '0);
  // An open line closes either on its first blank cycle or, if still open,
  // at vs_fall (closed into the ending frame without bumping y).
  assign w_line_close = w_line_open & (w_vs_fall | ~i_blank_n);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_vs_prev <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_vs_prev <= i_vs;
      if (w_vs_fall) begin
        // An active pixel on the vs_fall cycle is (0,0) of the new frame.
        r_x <= i_blank_n ? POS_W'(1) : '0;
        r_y <= '0;
      end else if (i_blank_n) begin
        if (r_x != POS_MAX) r_x <= r_x + POS_W'(1);
      end else if (w_line_open) begin
        r_x <= '0;
        if (r_y != POS_MAX) r_y <= r_y + POS_W'(1);
      end
    end
  end

  assign o_x       = w_vs_fall ? '0 : r_x;
  assign o_y       = w_vs_fall ? '0 : r_y;
  assign o_lines   = r_y;
  assign o_vs_fall = w_vs_fall;
  assign o_len_err = w_line_close & (r_x != WIDTH_P);

endmodule

// File: rtl/vga_frame_monitor.sv
// Border masking and per-frame statistics for a filtered VGA stream.
//   VGA_CLK, reset                  : pixel clock, synchronous active-high reset
//   iVGA_R/G/B, iVGA_HS/VS/SYNC_N/BLANK_N : input stream
//   oVGA_*                          : same stream, one cycle later, border masked
//   frame_valid                     : one-cycle pulse when statistics update
//   luma_sum, line_count            : luma total and line count of last frame
//   width_err, height_err           : geometry checks of last frame
module vga_frame_monitor
  import vga_pkg::*;
#(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 480,
  parameter int BORDER = 1,
  parameter int SUM_W  = 32
) (
  input  logic             VGA_CLK,
  input  logic             reset,
  input  logic [7:0]       iVGA_R,
  input  logic [7:0]       iVGA_G,
  input  logic [7:0]       iVGA_B,
  input  logic             iVGA_HS,
  input  logic             iVGA_VS,
  input  logic             iVGA_SYNC_N,
  input  logic             iVGA_BLANK_N,
  output logic [7:0]       oVGA_R,
  output logic [7:0]       oVGA_G,
  output logic [7:0]       oVGA_B,
  output logic             oVGA_HS,
  output logic             oVGA_VS,
  output logic             oVGA_SYNC_N,
  output logic             oVGA_BLANK_N,
  output logic             frame_valid,
  output logic [SUM_W-1:0] luma_sum,
  output logic [15:0]      line_count,
  output logic             width_err,
  output logic             height_err
);

  localparam logic [POS_W-1:0] X_LO     = POS_W'(BORDER);
  localparam logic [POS_W-1:0] X_HI     = POS_W'(WIDTH - BORDER);
  localparam logic [POS_W-1:0] Y_LO     = POS_W'(BORDER);
  localparam logic [POS_W-1:0] Y_HI     = POS_W'(HEIGHT - BORDER);
  localparam logic [POS_W-1:0] HEIGHT_P = POS_W'(HEIGHT);

  logic [POS_W-1:0] w_x;
  logic [POS_W-1:0] w_y;
  logic [POS_W-1:0] w_lines;
  logic             w_vs_fall;
  logic             w_len_err;
  logic             w_mask;
  rgb_t             w_pix;
  logic [SUM_W-1:0] w_luma_ext;

  monitor_state_t   r_state;
  monitor_state_t   w_state_next;
  logic             w_accum;
  logic             w_latch;

  logic [SUM_W-1:0] r_sum;
  logic             r_width_flag;
  logic             r_frame_valid;
  logic [SUM_W-1:0] r_luma_sum;
  logic [15:0]      r_line_count;
  logic             r_width_err;
  logic             r_height_err;
  rgb_t             r_pix;
  logic             r_hs;
  logic             r_vs;
  logic             r_sync_n;
  logic             r_blank_n;

  vga_position_counter #(
    .WIDTH (WIDTH)
  ) u_pos (
    .i_clk     (VGA_CLK),
    .i_srst    (reset),
    .i_blank_n (iVGA_BLANK_N),
    .i_vs      (iVGA_VS),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_lines   (w_lines),
    .o_vs_fall (w_vs_fall),
    .o_len_err (w_len_err)
  );

  assign w_pix      = {iVGA_R, iVGA_G, iVGA_B};
  assign w_luma_ext = {{(SUM_W-8){1'b0}}, luma(w_pix)};
  assign w_mask     = iVGA_BLANK_N &
                      ((w_x < X_LO) | (w_x >= X_HI) | (w_y < Y_LO) | (w_y >= Y_HI));

  always_comb begin
    w_state_next = r_state;
    w_accum      = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      SEEK:    if (w_vs_fall) w_state_next = FRAME;
      FRAME: begin
        w_accum = 1'b1;
        w_latch = w_vs_fall;
      end
      default: w_state_next = SEEK;
    endcase
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      r_state       <= SEEK;
      r_sum         <= '0;
      r_width_flag  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_luma_sum    <= '0;
      r_line_count  <= '0;
      r_width_err   <= 1'b0;
      r_height_err  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_frame_valid <= w_latch;
      if (w_latch) begin
        // The line still open at vs_fall contributes its length check here.
        r_luma_sum   <= r_sum;
        r_line_count <= w_lines;
        r_width_err  <= r_width_flag | w_len_err;
        r_height_err <= (w_lines != HEIGHT_P);
      end
      if (w_vs_fall) begin
        // Restart accumulation; an active pixel on this cycle opens the new frame.
        r_sum        <= iVGA_BLANK_N ? w_luma_ext : '0;
        r_width_flag <= 1'b0;
      end else if (w_accum) begin
        if (iVGA_BLANK_N) r_sum <= r_sum + w_luma_ext;
        if (w_len_err) r_width_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      r_pix     <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_sync_n  <= 1'b0;
      r_blank_n <= 1'b0;
    end else begin
      r_pix     <= w_mask ? '0 : w_pix;
      r_hs      <= iVGA_HS;
      r_vs      <= iVGA_VS;
      r_sync_n  <= iVGA_SYNC_N;
      r_blank_n <= iVGA_BLANK_N;
    end
  end

  assign oVGA_R       = r_pix.r;
  assign oVGA_G       = r_pix.g;
  assign oVGA_B       = r_pix.b;
  assign oVGA_HS      = r_hs;
  assign oVGA_VS      = r_vs;
  assign oVGA_SYNC_N  = r_sync_n;
  assign oVGA_BLANK_N = r_blank_n;
  assign frame_valid  = r_frame_valid;
  assign luma_sum     = r_luma_sum;
  assign line_count   = r_line_count;
  assign width_err    = r_width_err;
  assign height_err   = r_height_err;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Self-checking bench for vga_frame_monitor (WIDTH=8, HEIGHT=4, BORDER=1).
// A frame-level reference model records the lines and pixel lumas of the
// current frame and derives outputs from them each cycle.
module tb_vga_frame_monitor;

  localparam int W = 8;
  localparam int H = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ir, ig, ib;
  logic        ihs, ivs, isn, ibn;
  logic [7:0]  o_r, o_g, o_b;
  logic        o_hs, o_vs, o_sn, o_bn;
  logic        fv;
  logic [31:0] lsum;
  logic [15:0] lcnt;
  logic        werr, herr;

  always #20 clk = ~clk;

  vga_frame_monitor #(
    .WIDTH (W), .HEIGHT (H), .BORDER (B), .SUM_W (32)
  ) dut (
    .VGA_CLK (clk), .reset (rst),
    .iVGA_R (ir), .iVGA_G (ig), .iVGA_B (ib),
    .iVGA_HS (ihs), .iVGA_VS (ivs), .iVGA_SYNC_N (isn), .iVGA_BLANK_N (ibn),
    .oVGA_R (o_r), .oVGA_G (o_g), .oVGA_B (o_b),
    .oVGA_HS (o_hs), .oVGA_VS (o_vs), .oVGA_SYNC_N (o_sn), .oVGA_BLANK_N (o_bn),
    .frame_valid (fv), .luma_sum (lsum), .line_count (lcnt),
    .width_err (werr), .height_err (herr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  bit   m_prev_vs;
  bit   m_in_frame;
  int   m_cur_len;
  int   m_lines[$];
  int   m_pix[$];

  logic [7:0]  e_r, e_g, e_b;
  logic        e_hs, e_vs, e_sn, e_bn, e_fv, e_we, e_he;
  logic [31:0] e_sum;
  logic [15:0] e_lc;

  function automatic int luma_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return (int'(r) + 2 * int'(g) + int'(b)) / 4;
  endfunction

  task automatic model_step(input bit rs, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic hs, input logic vs,
                            input logic sn, input logic bn);
    bit     fall, masked, we;
    int     px, py;
    longint s;
    if (rs) begin
      e_r = 8'd0; e_g = 8'd0; e_b = 8'd0;
      e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_sn = 1'b0;
      e_fv = 1'b0; e_sum = 32'd0; e_lc = 16'd0; e_we = 1'b0; e_he = 1'b0;
      m_prev_vs = 1'b0; m_in_frame = 1'b0; m_cur_len = 0;
      m_lines.delete(); m_pix.delete();
    end else begin
      fall = m_prev_vs && !vs;
      m_prev_vs = vs;
      px = fall ? 0 : m_cur_len;
      py = fall ? 0 : m_lines.size();
      masked = bn && (px < B || px >= W - B || py < B || py >= H - B);
      e_r = masked ? 8'd0 : r;
      e_g = masked ? 8'd0 : g;
      e_b = masked ? 8'd0 : b;
      e_hs = hs; e_vs = vs; e_sn = sn; e_bn = bn;
      e_fv = 1'b0;
      if (fall) begin
        if (m_in_frame) begin
          s = 0;
          foreach (m_pix[i]) s += m_pix[i];
          we = (m_cur_len != 0 && m_cur_len != W);
          foreach (m_lines[i]) if (m_lines[i] != W) we = 1'b1;
          e_fv  = 1'b1;
          e_sum = s[31:0];
          e_lc  = 16'(m_lines.size());
          e_we  = we;
          e_he  = (m_lines.size() != H);
          $display("frame: luma_sum=%0d line_count=%0d width_err=%0d height_err=%0d",
                   e_sum, e_lc, e_we, e_he);
        end
        m_lines.delete();
        m_pix.delete();
        m_in_frame = 1'b1;
        m_cur_len = 0;
      end
      if (bn) begin
        m_cur_len++;
        m_pix.push_back(luma_of(r, g, b));
      end else if (m_cur_len > 0) begin
        m_lines.push_back(m_cur_len);
        m_cur_len = 0;
      end
    end
  endtask

  // One clock: drive, predict, clock, compare every output.
  task automatic cycle(input bit rs, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic hs, input logic vs,
                       input logic sn, input logic bn);
    rst = rs; ir = r; ig = g; ib = b; ihs = hs; ivs = vs; isn = sn; ibn = bn;
    model_step(rs, r, g, b, hs, vs, sn, bn);
    @(posedge clk);
    #1;
    check("video", 64'({o_r, o_g, o_b, o_hs, o_vs, o_sn, o_bn}),
          64'({e_r, e_g, e_b, e_hs, e_vs, e_sn, e_bn}));
    check("frame_valid", 64'(fv), 64'(e_fv));
    check("luma_sum", 64'(lsum), 64'(e_sum));
    check("line_count", 64'(lcnt), 64'(e_lc));
    check("width_err", 64'(werr), 64'(e_we));
    check("height_err", 64'(herr), 64'(e_he));
  endtask

  task automatic pix(input logic [7:0] v);
    cycle(1'b0, v, v, v, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic blank(input logic vs);
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, vs, 1'b1, 1'b0);
  endtask

  task automatic send_lines(input int n, input int short_idx, input int short_len,
                            input logic [7:0] v);
    for (int l = 0; l < n; l++) begin
      int len;
      len = (l == short_idx) ? short_len : W;
      for (int x = 0; x < len; x++) pix(v);
      blank(1'b1);
      blank(1'b1);
    end
  endtask

  task automatic frame_tail();
    blank(1'b0);
    blank(1'b1);
    blank(1'b1);
  endtask

  task automatic check_stats(input string tag, input logic e_v, input int s,
                             input int lc, input logic we, input logic he);
    check({tag, "_fv"}, 64'(fv), 64'(e_v));
    check({tag, "_sum"}, 64'(lsum), 64'(s));
    check({tag, "_lc"}, 64'(lcnt), 64'(lc));
    check({tag, "_werr"}, 64'(werr), 64'(we));
    check({tag, "_herr"}, 64'(herr), 64'(he));
  endtask

  typedef struct {
    int   nlines;
    int   short_idx;
    int   short_len;
    logic exp_fv;
    int   exp_sum;
    int   exp_lc;
    logic exp_we;
    logic exp_he;
  } vec_t;

  vec_t vt[6];
  logic vs_lvl;

  initial begin
    // Each entry's expectations describe the pulse at the vs_fall that starts
    // that entry's frame (i.e. they report the previous entry's frame).
    vt[0] = '{4, -1, 0, 1'b0,    0, 0, 1'b0, 1'b0};
    vt[1] = '{4, -1, 0, 1'b1, 3200, 4, 1'b0, 1'b0};
    vt[2] = '{4,  1, 7, 1'b1, 3200, 4, 1'b0, 1'b0};
    vt[3] = '{5, -1, 0, 1'b1, 3100, 4, 1'b1, 1'b0};
    vt[4] = '{4, -1, 0, 1'b1, 4000, 5, 1'b0, 1'b1};
    vt[5] = '{4, -1, 0, 1'b1, 3200, 4, 1'b0, 1'b0};

    // Reset values.
    cycle(1'b1, 8'd77, 8'd77, 8'd77, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_rgb", 64'({o_r, o_g, o_b}), 64'd0);
    check("rst_sync", 64'({o_hs, o_vs, o_bn, o_sn}), 64'b1100);
    check_stats("rst", 1'b0, 0, 0, 1'b0, 1'b0);
    blank(1'b1);
    blank(1'b1);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      blank(1'b0);
      check_stats($sformatf("tbl%0d", i), vt[i].exp_fv, vt[i].exp_sum,
                  vt[i].exp_lc, vt[i].exp_we, vt[i].exp_he);
      frame_tail();
      send_lines(vt[i].nlines, vt[i].short_idx, vt[i].short_len, 8'd100);
    end

    // Border masking on a frame of 200-valued pixels.
    blank(1'b0);
    check_stats("mask_start", 1'b1, 3200, 4, 1'b0, 1'b0);
    frame_tail();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        pix(8'd200);
        if ((x == 0 && y == 0) || (x == 7 && y == 2) || (x == 3 && y == 3))
          check($sformatf("mask_%0d_%0d", x, y), 64'({o_r, o_g, o_b}), 64'd0);
        if (x == 3 && y == 1)
          check("pass_3_1", 64'({o_r, o_g, o_b}), 64'h00C8C8C8);
      end
      cycle(1'b0, 8'd9, 8'd9, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      check("hs_delay0", 64'({o_hs, o_sn, o_r}), 64'h009);
      cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("hs_delay1", 64'({o_hs, o_sn}), 64'b11);
    end

    // 100-valued frame, then an active 50 pixel on its closing vs_fall.
    blank(1'b0);
    check_stats("after_mask", 1'b1, 6400, 4, 1'b0, 1'b0);
    frame_tail();
    send_lines(4, -1, 0, 8'd100);
    cycle(1'b0, 8'd50, 8'd50, 8'd50, 1'b1, 1'b0, 1'b1, 1'b1);
    check_stats("fall_pix", 1'b1, 3200, 4, 1'b0, 1'b0);
    check("fall_pix_masked", 64'({o_r, o_g, o_b}), 64'd0);
    for (int x = 1; x < W; x++) pix(8'd100);
    blank(1'b1);
    blank(1'b1);
    send_lines(3, -1, 0, 8'd100);
    blank(1'b0);
    check_stats("fall_pix_next", 1'b1, 3150, 4, 1'b0, 1'b0);
    frame_tail();

    // Reset for one cycle in the middle of a line.
    send_lines(1, -1, 0, 8'd100);
    pix(8'd100);
    pix(8'd100);
    cycle(1'b1, 8'd100, 8'd100, 8'd100, 1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst_rgb", 64'({o_r, o_g, o_b}), 64'd0);
    check("midrst_sync", 64'({o_hs, o_vs, o_bn, o_sn}), 64'b1100);
    check_stats("midrst", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int x = 0; x < 5; x++) pix(8'd100);
    blank(1'b1);
    send_lines(2, -1, 0, 8'd100);
    blank(1'b0);
    check_stats("midrst_fall1", 1'b0, 0, 0, 1'b0, 1'b0);
    frame_tail();
    send_lines(4, -1, 0, 8'd100);
    blank(1'b0);
    check_stats("midrst_fall2", 1'b1, 3200, 4, 1'b0, 1'b0);
    frame_tail();

    // Randomized stream against the model.
    vs_lvl = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      bit   rs;
      logic bn;
      rs = ($urandom_range(0, 899) == 0);
      if (vs_lvl && $urandom_range(0, 119) == 0) vs_lvl = 1'b0;
      else if (!vs_lvl && $urandom_range(0, 2) == 0) vs_lvl = 1'b1;
      bn = ($urandom_range(0, 9) < 7);
      cycle(rs, 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), vs_lvl, 1'($urandom_range(0, 1)), bn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Downstream stage placed directly after the convolution filter on the 25 MHz VGA stream. It reconstructs pixel coordinates from BLANK_N/VS, blacks out a configurable border where 3×3 kernel outputs are invalid, and forwards the stream with one cycle of latency. It also accumulates per-frame luma statistics and geometry checks, latching them at every vertical-sync falling edge for display or debug.

## Interface
- WIDTH, 800: expected active pixels per line.
- HEIGHT, 480: expected active lines per frame.
- BORDER, 1: pixels masked to black on each edge. Must satisfy 0 ≤ BORDER < min(WIDTH, HEIGHT)/2.
- SUM_W, 32: width of the luma accumulator.
- VGA_CLK, in, 1: 25 MHz pixel clock. The block's only clock.
- reset, in, 1: synchronous, active-high.
- iVGA_R / iVGA_G / iVGA_B, in, 8 each: filtered colour.
- iVGA_HS, iVGA_VS, iVGA_SYNC_N, iVGA_BLANK_N, in, 1 each: sync and blank signals, aligned with the colour inputs.
- oVGA_R / oVGA_G / oVGA_B, out, 8 each: colour after border masking.
- oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N, out, 1 each: delayed sync and blank.
- frame_valid, out, 1: one-cycle pulse when the statistics below update.
- luma_sum, out, SUM_W: sum of luma over the last complete frame.
- line_count, out, 16: active lines counted in the last frame.
- width_err, out, 1: last frame contained at least one active line whose length ≠ WIDTH.
- height_err, out, 1: last frame's line_count ≠ HEIGHT.

## Operation
- Luma per active pixel: (R + 2G + B) >> 2, computed at 10 bits and truncated to 8 bits.
- vs_fall is true when the registered previous VS is 1 and the current iVGA_VS is 0.
- Position tracking:
  - x counts the active (BLANK_N=1) cycles within the current line.
  - A line ends on the first cycle with BLANK_N=0 after an active run. At that point: y increments, the line length is checked against WIDTH (sets a sticky per-frame width flag), and x clears.
  - x and y saturate at their maximum value and never wrap.
- Masking: an active pixel at (x, y) is forced to RGB = 0 if x < BORDER, x ≥ WIDTH−BORDER, y < BORDER, or y ≥ HEIGHT−BORDER. All other pixels pass unchanged. Blank-period colour passes unchanged.
- FSM states:
  - SEEK (entered on reset): pixels pass through masking, but no statistics are accumulated. On vs_fall: clear counters, go to FRAME, no pulse.
  - FRAME: accumulate luma and run the line checks. On vs_fall: latch luma_sum, line_count, width_err and height_err (height_err = y ≠ HEIGHT), pulse frame_valid, clear the accumulators, stay in FRAME.
- Simultaneous events:
  - A pixel with BLANK_N=1 on the vs_fall cycle belongs to the new frame at (0,0). It is excluded from the latched sum and counted in the next one.
  - A line open at vs_fall is closed into the ending frame. Its length check is included, but it does not increment y.
- Reset mid-frame: state goes to SEEK, all counters and statistics clear, and the next vs_fall does not pulse.

## Timing
- Video path latency: exactly 1 cycle for all eight o* outputs. The mask decision uses the pre-increment x and y of the same input cycle.
- Statistics outputs change only on the frame_valid cycle, one cycle after the vs_fall input cycle.
- Reset values (next edge with reset=1):
  - oVGA_R/G/B = 0; oVGA_HS = 1, oVGA_VS = 1, oVGA_BLANK_N = 0, oVGA_SYNC_N = 0.
  - frame_valid = 0, luma_sum = 0, line_count = 0, width_err = 0, height_err = 0.
- The previous-VS register resets to 0, so a VS already low at reset release does not create a vs_fall.
- Maximum throughput: one pixel per clock. No stalls and no backpressure.

## Structure
- Shared package vga_pkg:
  - typedef rgb_t, a packed struct {r, g, b} of 8 bits each.
  - monitor_state_t enum {SEEK, FRAME}.
  - Luma function.
- One sub-module, vga_position_counter, owns the x/y counters, end-of-line detection, vs_fall detection and the line-length check. The top level holds masking, the accumulator, the FSM and the output registers.

## Test plan
All scenarios use WIDTH=8, HEIGHT=4, BORDER=1.
- Reset, then two frames of 8×4 with R=G=B=100: first vs_fall gives no pulse; second gives frame_valid=1 for 1 cycle, luma_sum=3200, line_count=4, width_err=0, height_err=0.
- Border masking with all input pixels =200: pixels at (0,0), (7,2) and (3,3) output RGB=0 one cycle later; pixel (3,1) outputs 200. Sync outputs equal the inputs delayed by 1 cycle.
- One 7-pixel line inside an otherwise valid frame: next pulse gives width_err=1. The following clean frame gives width_err=0.
- Frame of 5 lines: line_count=5, height_err=1.
- Reset asserted for 1 cycle mid-frame: next cycle shows the reset values; the next vs_fall gives no pulse; the frame after that reports correctly.
- Pixel value 50 (R=G=B) with BLANK_N=1 on the vs_fall cycle of a 100-valued frame: latched luma_sum=3200; the next frame's sum includes the 50.
